// File: rtl/serial_sort_node.sv
`default_nettype none
// ============================================================================
// Module   : serial_sort_node
// Brief    : Serial-in/serial-out N x W-bit sorting node with an LFSR frame
//            generator for first-layer operation.
// Revision : 1.0 - initial release
// ============================================================================
module serial_sort_node #(
    parameter int          W       = 4,
    parameter int          N       = 8,
    parameter int          DESCEND = 0,
    parameter logic [15:0] SEED    = 16'hACE1
) (
    input  logic t_clk,
    input  logic rst_n,
    input  logic f_layer,
    input  logic data_in,
    input  logic data_in_vld,
    output logic data_out,
    output logic data_out_vld,
    output logic sort_finish
);

    localparam int                 c_bits      = N * W;
    localparam int                 c_cnt_w     = $clog2(c_bits + 1);
    localparam logic [c_cnt_w-1:0] c_one       = c_cnt_w'(1);
    localparam logic [c_cnt_w-1:0] c_bit_last  = c_cnt_w'(c_bits - 1);
    localparam logic [c_cnt_w-1:0] c_elem_last = c_cnt_w'(N - 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_GEN  = 3'd1,
        S_LOAD = 3'd2,
        S_SORT = 3'd3,
        S_SEND = 3'd4,
        S_DONE = 3'd5
    } state_t;

    state_t               r_state;
    state_t               w_state_next;
    logic [c_cnt_w-1:0]   r_cnt;
    logic [c_cnt_w-1:0]   w_cnt_inc;
    logic                 w_leave;
    logic [15:0]          r_lfsr;
    logic [15:0]          w_lfsr_next;
    // Element i lives at r_frame[(N-1-i)*W +: W], so the frame MSB is element 0's MSB.
    logic [c_bits-1:0]    r_frame;
    logic [c_bits-1:0]    w_frame_sorted;
    logic [W-1:0]         w_elem   [N];
    logic [W-1:0]         w_sorted [N];
    logic                 r_data_out;
    logic                 r_data_out_vld;
    logic                 r_sort_finish;

    assign w_cnt_inc   = r_cnt + c_one;
    assign w_leave     = (w_state_next != r_state);
    assign w_lfsr_next = {r_lfsr[0] ^ r_lfsr[2] ^ r_lfsr[3] ^ r_lfsr[5], r_lfsr[15:1]};

    always_ff @(posedge t_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (f_layer) begin
                    w_state_next = S_GEN;
                end else if (data_in_vld) begin
                    w_state_next = S_LOAD;
                end
            end
            S_GEN:  if (r_cnt == c_elem_last) w_state_next = S_SORT;
            S_LOAD: if (data_in_vld && (r_cnt == c_bit_last)) w_state_next = S_SORT;
            S_SORT: if (r_cnt == c_elem_last) w_state_next = S_SEND;
            S_SEND: if (r_cnt == c_bit_last) w_state_next = S_DONE;
            S_DONE: w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // One odd-even transposition phase; the phase parity selects the pairing.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            w_elem[i] = r_frame[(N-1-i)*W +: W];
        end
        w_sorted = w_elem;
        for (int i = 0; i < N - 1; i++) begin
            if (i[0] == r_cnt[0]) begin
                if ((DESCEND != 0) ? (w_elem[i] < w_elem[i+1]) : (w_elem[i] > w_elem[i+1])) begin
                    w_sorted[i]   = w_elem[i+1];
                    w_sorted[i+1] = w_elem[i];
                end
            end
        end
        w_frame_sorted = '0;
        for (int i = 0; i < N; i++) begin
            w_frame_sorted[(N-1-i)*W +: W] = w_sorted[i];
        end
    end

    always_ff @(posedge t_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt          <= '0;
            r_lfsr         <= SEED;
            r_frame        <= '0;
            r_data_out     <= 1'b0;
            r_data_out_vld <= 1'b0;
            r_sort_finish  <= 1'b0;
        end else begin
            r_data_out     <= 1'b0;
            r_data_out_vld <= 1'b0;
            r_sort_finish  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_cnt <= '0;
                    if (!f_layer && data_in_vld) begin
                        r_frame <= {r_frame[c_bits-2:0], data_in};
                        r_cnt   <= c_one;
                    end
                end
                S_GEN: begin
                    r_frame <= {r_frame[c_bits-W-1:0], r_lfsr[W-1:0]};
                    r_lfsr  <= w_lfsr_next;
                    r_cnt   <= w_leave ? '0 : w_cnt_inc;
                end
                S_LOAD: begin
                    if (data_in_vld) begin
                        r_frame <= {r_frame[c_bits-2:0], data_in};
                        r_cnt   <= w_leave ? '0 : w_cnt_inc;
                    end
                end
                S_SORT: begin
                    r_frame <= w_frame_sorted;
                    r_cnt   <= w_leave ? '0 : w_cnt_inc;
                end
                S_SEND: begin
                    r_data_out     <= r_frame[c_bits-1];
                    r_data_out_vld <= 1'b1;
                    r_frame        <= {r_frame[c_bits-2:0], 1'b0};
                    r_cnt          <= w_leave ? '0 : w_cnt_inc;
                end
                S_DONE: begin
                    r_sort_finish <= 1'b1;
                    r_cnt         <= '0;
                end
                default: r_cnt <= '0;
            endcase
        end
    end

    assign data_out     = r_data_out;
    assign data_out_vld = r_data_out_vld;
    assign sort_finish  = r_sort_finish;

endmodule
`default_nettype wire

// File: tb/tb_serial_sort_node.sv
`default_nettype none
// ============================================================================
// Module   : tb_serial_sort_node
// Brief    : Scoreboard bench for serial_sort_node (W4/N8 both orders, W8/N16).
// Revision : 1.0 - initial release
// ============================================================================
module tb_serial_sort_node;

    localparam int NA = 8;
    localparam int WA = 4;
    localparam int NB = 16;
    localparam int WB = 8;

    logic t_clk = 1'b0;
    logic rst_n_ab, rst_n_b, f_layer, din_ab, vld_ab, din_b, vld_b, f_layer_b;
    logic out_a, ov_a, fs_a, out_d, ov_d, fs_d, out_b, ov_b, fs_b;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    bit q_a[$];
    bit q_d[$];
    bit q_b[$];
    int fin_a = 0, fin_d = 0, fin_b = 0;
    int run_a = 0, run_d = 0, run_b = 0;
    int last_a = 0, last_b = 0;
    bit arm_a = 0, arm_b = 0;
    logic pv_a = 1'b0, pv_b = 1'b0;

    serial_sort_node #(.W(WA), .N(NA), .DESCEND(0)) dut_a (
        .t_clk(t_clk), .rst_n(rst_n_ab), .f_layer(f_layer), .data_in(din_ab),
        .data_in_vld(vld_ab), .data_out(out_a), .data_out_vld(ov_a), .sort_finish(fs_a));
    serial_sort_node #(.W(WA), .N(NA), .DESCEND(1)) dut_d (
        .t_clk(t_clk), .rst_n(rst_n_ab), .f_layer(f_layer), .data_in(din_ab),
        .data_in_vld(vld_ab), .data_out(out_d), .data_out_vld(ov_d), .sort_finish(fs_d));
    serial_sort_node #(.W(WB), .N(NB), .DESCEND(0)) dut_b (
        .t_clk(t_clk), .rst_n(rst_n_b), .f_layer(f_layer_b), .data_in(din_b),
        .data_in_vld(vld_b), .data_out(out_b), .data_out_vld(ov_b), .sort_finish(fs_b));

    always #5 t_clk = ~t_clk;
    always @(posedge t_clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Scoreboard side: outputs sampled on the falling edge.
    always @(negedge t_clk) begin
        if (fs_a) begin
            check_eq("a_run_len", run_a, NA*WA); fin_a++; run_a = 0;
        end else if (ov_a) begin
            if (!pv_a && arm_a) begin check_eq("a_latency", cyc - last_a, NA+1); arm_a = 0; end
            run_a++;
            if (q_a.size() == 0) check_eq("a_extra_bit", 1, 0);
            else check_eq("a_bit", int'(out_a), int'(q_a.pop_front()));
        end else begin
            run_a = 0;
            if (out_a) check_eq("a_out_idle", int'(out_a), 0);
        end
        pv_a = ov_a;

        if (fs_d) begin
            check_eq("d_run_len", run_d, NA*WA); fin_d++; run_d = 0;
        end else if (ov_d) begin
            run_d++;
            if (q_d.size() == 0) check_eq("d_extra_bit", 1, 0);
            else check_eq("d_bit", int'(out_d), int'(q_d.pop_front()));
        end else begin
            run_d = 0;
            if (out_d) check_eq("d_out_idle", int'(out_d), 0);
        end

        if (fs_b) begin
            check_eq("b_run_len", run_b, NB*WB); fin_b++; run_b = 0;
        end else if (ov_b) begin
            if (!pv_b && arm_b) begin check_eq("b_latency", cyc - last_b, NB+1); arm_b = 0; end
            run_b++;
            if (q_b.size() == 0) check_eq("b_extra_bit", 1, 0);
            else check_eq("b_bit", int'(out_b), int'(q_b.pop_front()));
        end else begin
            run_b = 0;
            if (out_b) check_eq("b_out_idle", int'(out_b), 0);
        end
        pv_b = ov_b;
    end

    // Frame packing: element 0 in the top nibble/byte.
    task automatic push_ab(input logic [31:0] f);
        int e[NA];
        int t;
        for (int i = 0; i < NA; i++) e[i] = int'(f[31-4*i -: 4]);
        for (int i = 0; i < NA; i++)
            for (int j = i + 1; j < NA; j++)
                if (e[j] < e[i]) begin t = e[i]; e[i] = e[j]; e[j] = t; end
        for (int i = 0; i < NA; i++)
            for (int b = WA - 1; b >= 0; b--) q_a.push_back(e[i][b]);
        for (int i = NA - 1; i >= 0; i--)
            for (int b = WA - 1; b >= 0; b--) q_d.push_back(e[i][b]);
    endtask

    task automatic push_b(input logic [127:0] f);
        int e[NB];
        int t;
        for (int i = 0; i < NB; i++) e[i] = int'(f[127-8*i -: 8]);
        for (int i = 0; i < NB; i++)
            for (int j = i + 1; j < NB; j++)
                if (e[j] < e[i]) begin t = e[i]; e[i] = e[j]; e[j] = t; end
        for (int i = 0; i < NB; i++)
            for (int b = WB - 1; b >= 0; b--) q_b.push_back(e[i][b]);
    endtask

    task automatic drive_ab(input logic [31:0] f, input bit gaps);
        push_ab(f);
        for (int k = 0; k < NA*WA; k++) begin
            if (gaps) begin
                vld_ab = 1'b0;
                din_ab = 1'($urandom);
                repeat ($urandom_range(0, 2)) @(posedge t_clk);
                #1;
            end
            din_ab = f[31-k];
            vld_ab = 1'b1;
            @(posedge t_clk); #1;
        end
        vld_ab = 1'b0; din_ab = 1'b0;
        last_a = cyc; arm_a = 1;
    endtask

    task automatic drive_b(input logic [127:0] f);
        push_b(f);
        for (int k = 0; k < NB*WB; k++) begin
            din_b = f[127-k]; vld_b = 1'b1;
            @(posedge t_clk); #1;
        end
        vld_b = 1'b0; din_b = 1'b0;
        last_b = cyc; arm_b = 1;
    endtask

    task automatic wait_ab(input int target);
        for (int c = 0; c < 400 && fin_a < target; c++) begin @(posedge t_clk); #1; end
        check_eq("a_finish_count", fin_a, target);
        check_eq("d_finish_count", fin_d, target);
        check_eq("a_queue_empty", q_a.size(), 0);
        check_eq("d_queue_empty", q_d.size(), 0);
    endtask

    task automatic wait_b(input int target);
        for (int c = 0; c < 800 && fin_b < target; c++) begin @(posedge t_clk); #1; end
        check_eq("b_finish_count", fin_b, target);
        check_eq("b_queue_empty", q_b.size(), 0);
    endtask

    task automatic reset_ab_now(input string tag);
        int f0;
        f0 = fin_a;
        rst_n_ab = 1'b0; #1;
        check_eq({tag, "_a_outs"}, int'({out_a, ov_a, fs_a}), 0);
        check_eq({tag, "_d_outs"}, int'({out_d, ov_d, fs_d}), 0);
        q_a.delete(); q_d.delete(); arm_a = 0;
        @(posedge t_clk); #1;
        rst_n_ab = 1'b1;
        repeat (4) @(posedge t_clk); #1;
        check_eq({tag, "_no_finish"}, fin_a, f0);
    endtask

    initial begin
        logic [15:0]  lfsr;
        logic [31:0]  g;
        logic [127:0] fb;
        int           tgt;
        rst_n_ab = 0; rst_n_b = 0; f_layer = 0; f_layer_b = 0;
        din_ab = 0; vld_ab = 0; din_b = 0; vld_b = 0;
        repeat (3) @(posedge t_clk); #1;
        check_eq("reset_a", int'({out_a, ov_a, fs_a}), 0);
        check_eq("reset_d", int'({out_d, ov_d, fs_d}), 0);
        check_eq("reset_b", int'({out_b, ov_b, fs_b}), 0);
        rst_n_ab = 1; rst_n_b = 1;
        repeat (2) @(posedge t_clk); #1;

        // Self-generated frames: two back-to-back from the continuing LFSR.
        lfsr = 16'hACE1;
        for (int fr = 0; fr < 2; fr++) begin
            for (int i = 0; i < NA; i++) begin
                g[31-4*i -: 4] = lfsr[3:0];
                lfsr = {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
            end
            push_ab(g);
        end
        f_layer = 1'b1;
        for (int c = 0; c < 300 && fin_a < 1; c++) @(posedge t_clk);
        #1; f_layer = 1'b0;
        check_eq("gen_first_finish", fin_a, 1);
        wait_ab(2);
        tgt = 2;

        drive_ab(32'hEDE187AF, 0); tgt++; wait_ab(tgt);
        drive_ab(32'hEDE187AF, 1); tgt++; wait_ab(tgt);
        drive_ab(32'h00000000, 0); tgt++; wait_ab(tgt);
        drive_ab(32'hFFFFFFFF, 0); tgt++; wait_ab(tgt);
        drive_ab(32'h01234567, 0); tgt++; wait_ab(tgt);
        drive_ab(32'hFEDCBA98, 0); tgt++; wait_ab(tgt);
        drive_ab(32'h5A5A0FF0, 1); tgt++; wait_ab(tgt);
        drive_ab($urandom, 0);     tgt++; wait_ab(tgt);

        drive_ab(32'h3C1F8E27, 0);
        repeat (3) @(posedge t_clk); #1;
        reset_ab_now("rst_sort");
        drive_ab(32'hEDE187AF, 0); tgt++; wait_ab(tgt);

        drive_ab(32'h9182736A, 0);
        repeat (NA + 7) @(posedge t_clk); #1;
        check_eq("a_send_active", int'(ov_a), 1);
        reset_ab_now("rst_send");
        drive_ab(32'hB4E2D0C1, 0); tgt++; wait_ab(tgt);

        fb = {$urandom, $urandom, $urandom, $urandom};
        drive_b(fb); wait_b(1);
        drive_b(fb);
        repeat (NB + 20) @(posedge t_clk); #1;
        check_eq("b_send_active", int'(ov_b), 1);
        rst_n_b = 1'b0; #1;
        check_eq("rst_send_b_outs", int'({out_b, ov_b, fs_b}), 0);
        q_b.delete(); arm_b = 0;
        @(posedge t_clk); #1; rst_n_b = 1'b1;
        repeat (4) @(posedge t_clk); #1;
        check_eq("rst_send_b_no_finish", fin_b, 1);
        drive_b(128'h00FF_00FF_7F80_0102_FF00_0000_8080_FE01); wait_b(2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule
`default_nettype wire
